// File: rtl/bit_pattern_pkg.sv
// Shared constants and state type for the serial pattern transmitter and its consumers.
package bit_pattern_pkg;

   localparam int DEF_PAT_W = 8;
   localparam int DEF_LEN_W = 3;
   localparam int DEF_CNT_W = 4;

   // Target sequence of the downstream Mealy detector; streams built for it use this.
   localparam logic [2:0] DET_PATTERN = 3'b101;
   localparam int         DET_LEN     = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bit_pattern_tx.sv
// Serial pattern transmitter: captures pattern/len/repeat_n on start, then shifts the
// pattern out MSB-first over a valid/ready link, repeat_n+1 times back to back.
module bit_pattern_tx
   import bit_pattern_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int LEN_W = DEF_LEN_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic             bit_ready,
   output logic             bit_out,
   output logic             bit_valid,
   output logic             busy,
   output logic             done,
   output state_t           dbg_state_o
);

   // Handshake: a bit moves on a rising edge where bit_valid and bit_ready are both 1;
   // while bit_ready is 0 the presented bit and bit_valid stay put.

   localparam logic [LEN_W:0] FULL_LEN = (LEN_W+1)'(PAT_W);

   state_t           state_q;
   logic [PAT_W-1:0] shift_q;
   logic [PAT_W-1:0] pat_q;
   logic [LEN_W:0]   len_q;
   logic [LEN_W:0]   bits_q;
   logic [CNT_W-1:0] pass_q;

   logic [LEN_W:0]   len_d;
   logic [PAT_W-1:0] pat_d;

   // Left-align the low len bits so the first bit to send always sits in the MSB.
   assign len_d = (len == '0) ? FULL_LEN : {1'b0, len};
   assign pat_d = pattern << (FULL_LEN - len_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         bits_q  <= '0;
         pass_q  <= '0;
      end else if (ena) begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  pat_q   <= pat_d;
                  shift_q <= pat_d;
                  len_q   <= len_d;
                  bits_q  <= len_d;
                  pass_q  <= repeat_n;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (bit_ready) begin
                  if (bits_q != 1) begin
                     shift_q <= shift_q << 1;
                     bits_q  <= bits_q - 1'b1;
                  end else if (pass_q != '0) begin
                     // Reload on the last transfer so the next pass follows with no gap.
                     shift_q <= pat_q;
                     bits_q  <= len_q;
                     pass_q  <= pass_q - 1'b1;
                  end else begin
                     shift_q <= shift_q << 1;
                     bits_q  <= '0;
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bit_out     = shift_q[PAT_W-1];
   assign bit_valid   = ena && (state_q == SHIFT);
   assign done        = ena && (state_q == DONE);
   assign busy        = (state_q != IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bit_pattern_tx.sv
// Bench for bit_pattern_tx: queue-based stream model checked every cycle, plus literal run results.
module tb_bit_pattern_tx;
  import bit_pattern_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [2:0] len = 3'd0;
  logic [3:0] repeat_n = 4'd0;
  logic       bit_ready = 1'b1;
  logic       bit_out, bit_valid, busy, done;
  state_t     dbg_state;

  bit_pattern_tx dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .pattern(pattern), .len(len), .repeat_n(repeat_n), .bit_ready(bit_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy), .done(done),
    .dbg_state_o(dbg_state)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [0:0]  exp_q[$];
  bit          m_done = 1'b0;
  logic [15:0] log_bits = 16'h0;
  int          log_n = 0;
  int          done_cnt = 0;
  int          done_cyc = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  function automatic int count_det(input logic [15:0] b, input int n);
    int c = 0;
    for (int i = 0; i + DET_LEN <= n; i++)
      if (b[i +: DET_LEN] == DET_PATTERN) c++;
    return c;
  endfunction

  // Model: the whole transmission is a queue of bits; once empty, one done cycle follows.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      m_done = 1'b0;
    end else if (ena) begin
      if (m_done) m_done = 1'b0;
      else if (exp_q.size() > 0) begin
        if (bit_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_done = 1'b1;
        end
      end else if (start) begin
        automatic int le = (len == 3'd0) ? 8 : int'(len);
        for (int p = 0; p <= int'(repeat_n); p++)
          for (int i = le - 1; i >= 0; i--)
            exp_q.push_back(pattern[i]);
      end
    end
  end

  // Compare process: every falling edge.
  initial begin
    logic e_valid, e_busy, e_done;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_bit_out", bit_out, 0);
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
      end else begin
        e_valid = ena && (exp_q.size() > 0);
        e_busy  = (exp_q.size() > 0) || m_done;
        e_done  = ena && m_done;
        chk("bit_valid", bit_valid, e_valid);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (e_valid) chk("bit_out", bit_out, exp_q[0]);
        if (bit_valid && bit_ready) begin
          log_bits = {log_bits[14:0], bit_out};
          log_n++;
        end
        if (done) begin
          done_cnt++;
          if (done_cyc < 0) done_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Cycle k=1 is the first cycle after the start edge; windows are [at, at+n).
  task automatic run_tx(input logic [7:0] pat, input logic [2:0] ln, input logic [3:0] rep,
                        input int rdy_at, input int rdy_n, input int ena_at, input int ena_n,
                        input int restart_at, output int done_rel);
    int e;
    @(posedge clk); #1;
    pattern = pat; len = ln; repeat_n = rep; start = 1'b1; bit_ready = 1'b1; ena = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = cyc;
    log_bits = 16'h0; log_n = 0; done_cnt = 0; done_cyc = -1;
    pattern = ~pat; len = ~ln; repeat_n = ~rep;
    for (int k = 1; k <= 60; k++) begin
      bit_ready = !(k >= rdy_at && k < rdy_at + rdy_n);
      ena = !(k >= ena_at && k < ena_at + ena_n);
      start = (k == restart_at);
      if (k == restart_at) pattern = 8'hFF;
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    start = 1'b0; ena = 1'b1; bit_ready = 1'b1;
    done_rel = (done_cyc < 0) ? -1 : done_cyc - e + 1;
  endtask

  task automatic check_run(input string nm, input int done_rel, input int exp_done,
                           input int exp_n, input logic [15:0] exp_bits, input int exp_match);
    logic [15:0] mask;
    mask = (16'd1 << exp_n) - 16'd1;
    chk({nm, "_done_cycle"}, done_rel, exp_done);
    chk({nm, "_nbits"}, log_n, exp_n);
    chk({nm, "_bits"}, log_bits & mask, exp_bits);
    chk({nm, "_det_matches"}, count_det(log_bits, log_n), exp_match);
    chk({nm, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    int dr;
    #1 rst_n = 1'b0;
    start = 1'b1; pattern = 8'h05; len = 3'd3;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("post_reset_busy", busy, 0);

    run_tx(8'h05, 3'd3, 4'd0, 0, 0, 0, 0, 0, dr);
    check_run("basic", dr, 4, 3, 16'h0005, 1);

    run_tx(8'h05, 3'd3, 4'd2, 0, 0, 0, 0, 0, dr);
    check_run("repeat", dr, 10, 9, 16'h016D, 3);

    run_tx(8'h05, 3'd3, 4'd0, 2, 3, 0, 0, 0, dr);
    check_run("backpressure", dr, 7, 3, 16'h0005, 1);

    run_tx(8'hA5, 3'd0, 4'd0, 0, 0, 0, 0, 4, dr);
    check_run("full_ignore_start", dr, 9, 8, 16'h00A5, 2);

    run_tx(8'hA5, 3'd0, 4'd0, 0, 0, 3, 4, 0, dr);
    check_run("ena_freeze", dr, 13, 8, 16'h00A5, 2);

    run_tx(8'hF6, 3'd5, 4'd1, 0, 0, 0, 0, 0, dr);
    check_run("len5_rep1", dr, 11, 10, 16'h02D6, 3);

    // Abort mid-pass with an asynchronous reset pulse.
    @(posedge clk); #1;
    pattern = 8'h05; len = 3'd3; repeat_n = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_bit_out", bit_out, 0);
    chk("abort_bit_valid", bit_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    done_cnt = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("abort_no_done", done_cnt, 0);

    run_tx(8'h06, 3'd3, 4'd0, 0, 0, 0, 0, 0, dr);
    check_run("after_abort", dr, 4, 3, 16'h0006, 0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bit_pattern_tx.md
Name: bit_pattern_tx

Overview:
- Serial pattern transmitter: the driving end of the serial bit stream consumed by the Mealy "101" sequence detector.
- Captures a parallel pattern with length and repeat count, then shifts it out MSB-first, one bit per accepted transfer, with a valid/ready handshake.
- Used as an on-chip stimulus source that can feed the detector through the tt_um top, and as the stream generator in benches.

Parameters:
- PAT_W, 8, pattern register width in bits.
- LEN_W, 3, width of len; equals $clog2(PAT_W).
- CNT_W, 4, width of the repeat count.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  global enable; low freezes all state.
- start  input  1  request to transmit; sampled on clk; accepted only in IDLE with ena=1.
- pattern  input  PAT_W  bits to send; only the low len bits are used.
- len  input  LEN_W  number of bits per pass; 0 means PAT_W.
- repeat_n  input  CNT_W  extra passes; total passes = repeat_n+1.
- bit_ready  input  1  downstream accepts the current bit.
- bit_out  output  1  current serial bit.
- bit_valid  output  1  bit_out holds a valid bit.
- busy  output  1  transmission in progress.
- done  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - State goes to IDLE.
  - bit_out=0, bit_valid=0, busy=0, done=0.
  - Shift register, bit counter and pass counter are cleared.
  - A reset mid-transmission aborts it with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1 and ena=1, capture pattern, len (0 becomes PAT_W) and repeat_n.
  - Load the shift register so that pattern[len-1] is the MSB, and go to SHIFT.
  - Latency: bit_valid=1 on the first cycle after the start edge.
- SHIFT:
  - bit_valid=1, bit_out = shift register MSB.
  - A transfer occurs on a clock edge with bit_valid and bit_ready both 1.
  - Each transfer shifts left by one and decrements bits-remaining.
  - While bit_ready=0, bit_out and bit_valid hold unchanged.
- Pass boundary:
  - On the transfer of the last bit of a pass with passes remaining: reload the shift register from the captured pattern, reset bits-remaining to len, decrement the pass counter.
  - No bubble: bit_valid stays 1 and the next pass's first bit appears on the following cycle.
- Final transfer:
  - Transfer of the last bit of the last pass moves the state to DONE.
  - bit_valid=0 in DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy is high in SHIFT and DONE, low in IDLE.
- start while busy is ignored; captured values are not disturbed.
- Input changes to pattern, len or repeat_n after capture have no effect.
- ena=0:
  - All registers hold.
  - bit_valid and done are gated low, so no transfer occurs.
  - State, bit position and pass count resume unchanged when ena returns high.
  - An active done pulse is delayed, not lost.
- Arithmetic:
  - Bit counter is LEN_W+1 bits wide so it can hold PAT_W.
  - Pass counter counts down from repeat_n to 0; no wrap.
  - Total bits sent = len_eff * (repeat_n+1).
- bit_out is a register output. bit_valid, busy and done are decoded from registered state, gated only by ena.

Decomposition:
- Shared package bit_pattern_pkg holds:
  - State enum (IDLE, SHIFT, DONE).
  - Default constants PAT_W=8, LEN_W=3, CNT_W=4.
  - The detector's target pattern constant, 3'b101 with length 3, shared with the detector and the benches.
- No sub-module: shift register, bit counter and pass counter stay inline; the whole block is one FSM plus datapath.

Test Plan:
- Reset: rst_n=0 for 3 cycles with start=1 -> bit_out=0, bit_valid=0, busy=0, done=0 throughout; no transmission starts until rst_n=1 and a new start.
- Basic: pattern=8'h05, len=3, repeat_n=0, bit_ready=1, single start pulse -> bit_valid=1 for cycles 1-3 with bit_out=1,0,1; done=1 in cycle 4 only; busy=1 in cycles 1-4. The detector fed this stream flags exactly one match.
- Repeat: pattern=8'h05, len=3, repeat_n=2 -> 9 contiguous valid cycles carrying 101101101, no gaps; then a single done pulse; the detector counts 3 matches.
- Backpressure: same as Basic, bit_ready=0 for 3 cycles while the 2nd bit is presented -> bit_out held at 0 and bit_valid held at 1; done arrives 3 cycles later than in Basic; bit sequence unchanged.
- Full width and ignored start: len=0, pattern=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1. A start pulse with pattern=8'hFF mid-stream has no effect on the sequence or timing.
- Abort and freeze:
  - ena=0 for 4 cycles mid-pass -> bit_valid=0 during the hold, then resumes at the same bit.
  - rst_n pulsed low mid-pass -> outputs 0 immediately, no done pulse; a following start sends the new pattern from its first bit.
